// File: rtl/fb_stream_reader.sv
// Framebuffer read streamer: walks a BRAM address range with one-cycle-latency reads
// and presents the pixels as a valid/ready stream through a 2-entry skid FIFO.
module fb_stream_reader #(
  parameter int unsigned ADDR_BITS = 8,
  parameter int unsigned LEN_BITS  = ADDR_BITS + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [ADDR_BITS-1:0] base_addr,
  input  logic [LEN_BITS-1:0]  len,
  output logic                 busy,
  output logic                 done,
  output logic [ADDR_BITS-1:0] raddr,
  output logic                 ren,
  input  logic [15:0]          rdata,
  output logic [15:0]          pix_data,
  output logic                 pix_valid,
  input  logic                 pix_ready,
  output logic                 pix_last
);

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DRAIN, S_FIN} state_t;

  state_t               state_q, state_d;
  logic [ADDR_BITS-1:0] base_q, base_d;
  logic [LEN_BITS-1:0]  len_q, len_d;
  logic [LEN_BITS-1:0]  issued_q, issued_d;
  logic [LEN_BITS-1:0]  delivered_q, delivered_d;
  logic [1:0]           occ_q, occ_d;
  logic                 inflight_q, inflight_d;
  logic [15:0]          e0_q, e0_d;
  logic [15:0]          e1_q, e1_d;
  logic [ADDR_BITS-1:0] raddr_q, raddr_d;
  logic                 pop;
  logic                 room;

  // State register and datapath flops
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      base_q      <= '0;
      len_q       <= '0;
      issued_q    <= '0;
      delivered_q <= '0;
      occ_q       <= '0;
      inflight_q  <= 1'b0;
      e0_q        <= '0;
      e1_q        <= '0;
      raddr_q     <= '0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      len_q       <= len_d;
      issued_q    <= issued_d;
      delivered_q <= delivered_d;
      occ_q       <= occ_d;
      inflight_q  <= inflight_d;
      e0_q        <= e0_d;
      e1_q        <= e1_d;
      raddr_q     <= raddr_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = (len == '0) ? S_FIN : S_STREAM;
      end
      S_STREAM: begin
        if (ren && (issued_q + LEN_BITS'(1) == len_q)) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (pop && (delivered_q + LEN_BITS'(1) == len_q)) state_d = S_FIN;
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs; the read is throttled so FIFO plus in-flight read never exceeds two pixels
  always_comb begin
    pix_valid = (occ_q != 2'd0);
    pix_data  = e0_q;
    pop       = pix_valid & pix_ready;
    room      = (({1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop}) < 3'd2);
    ren       = (state_q == S_STREAM) && (issued_q < len_q) && room;
    raddr     = ren ? (base_q + ADDR_BITS'(issued_q)) : raddr_q;
    busy      = (state_q != S_IDLE);
    done      = (state_q == S_FIN);
    pix_last  = pix_valid && (delivered_q == len_q - LEN_BITS'(1));
  end

  // Counters and shift-style skid FIFO (entry 0 is always the head)
  always_comb begin
    base_d      = base_q;
    len_d       = len_q;
    issued_d    = issued_q;
    delivered_d = delivered_q;
    occ_d       = occ_q;
    e0_d        = e0_q;
    e1_d        = e1_q;
    raddr_d     = raddr_q;
    inflight_d  = ren;

    if ((state_q == S_IDLE) && start) begin
      base_d      = base_addr;
      len_d       = len;
      issued_d    = '0;
      delivered_d = '0;
    end
    if (ren) begin
      issued_d = issued_q + LEN_BITS'(1);
      raddr_d  = raddr;
    end
    if (pop) delivered_d = delivered_q + LEN_BITS'(1);

    case ({inflight_q, pop})
      2'b10: begin
        if (occ_q == 2'd0) e0_d = rdata;
        else               e1_d = rdata;
        occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        e0_d  = e1_q;
        occ_d = occ_q - 2'd1;
      end
      2'b11: begin
        if (occ_q == 2'd1) begin
          e0_d = rdata;
        end else begin
          e0_d = e1_q;
          e1_d = rdata;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_fb_stream_reader.sv
// Directed bench for fb_stream_reader with a one-cycle-latency BRAM holding mem[a] = a*3.
module tb_fb_stream_reader;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  base_addr;
  logic [8:0]  len;
  logic        busy;
  logic        done;
  logic [7:0]  raddr;
  logic        ren;
  logic [15:0] rdata;
  logic [15:0] pix_data;
  logic        pix_valid;
  logic        pix_ready;
  logic        pix_last;

  int n_vec = 0;
  int n_err = 0;

  fb_stream_reader #(.ADDR_BITS(8), .LEN_BITS(9)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .len       (len),
    .busy      (busy),
    .done      (done),
    .raddr     (raddr),
    .ren       (ren),
    .rdata     (rdata),
    .pix_data  (pix_data),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .pix_last  (pix_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] exp_pix(input logic [7:0] a);
    return 16'(a) * 16'd3;
  endfunction

  // BRAM model
  always @(posedge clk) if (ren) rdata <= exp_pix(raddr);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, " busy"},      32'(busy),      32'd0);
    chk({nm, " done"},      32'(done),      32'd0);
    chk({nm, " ren"},       32'(ren),       32'd0);
    chk({nm, " raddr"},     32'(raddr),     32'd0);
    chk({nm, " pix_valid"}, 32'(pix_valid), 32'd0);
    chk({nm, " pix_last"},  32'(pix_last),  32'd0);
    chk({nm, " pix_data"},  32'(pix_data),  32'd0);
  endtask

  // Cycle 0 holds start high; returns mid-cycle 1 with start dropped
  task automatic do_start(input logic [7:0] b, input logic [8:0] l);
    @(negedge clk);
    start = 1'b1; base_addr = b; len = l;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_xfer(input string nm, input logic [7:0] b, input logic [8:0] l,
                          input logic [15:0] rpat, input int ign_cyc,
                          input int exp_done_cyc, input int budget);
    int nren, npop, nlast, idx, first_valid, last_ren;
    logic [15:0] held;
    logic stalled, fin;
    nren = 0; npop = 0; nlast = 0; idx = 0; first_valid = 0; last_ren = 0;
    held = '0; stalled = 1'b0; fin = 1'b0;
    do_start(b, l);
    for (int cyc = 1; cyc <= budget && !fin; cyc++) begin
      if (cyc > 1) @(negedge clk);
      pix_ready = rpat[cyc % 16];
      if (cyc == ign_cyc) begin
        start = 1'b1; base_addr = 8'h80; len = 9'd3;
      end else begin
        start = 1'b0;
      end
      #1;
      if (ren) begin
        chk({nm, " raddr"}, 32'(raddr), 32'(8'(b + 8'(nren))));
        nren++;
        last_ren = cyc;
      end
      if (stalled) begin
        chk({nm, " hold valid"}, 32'(pix_valid), 32'd1);
        chk({nm, " hold data"},  32'(pix_data),  32'(held));
      end
      if (pix_valid) begin
        if (first_valid == 0) first_valid = cyc;
        chk({nm, " pix_data"}, 32'(pix_data), 32'(exp_pix(8'(b + 8'(idx)))));
        chk({nm, " pix_last"}, 32'(pix_last), 32'(idx == int'(l) - 1));
        if (pix_ready) begin
          if (pix_last) nlast++;
          npop++;
          idx++;
        end
      end
      stalled = pix_valid && !pix_ready;
      held    = pix_data;
      chk({nm, " outstanding>2"}, 32'((nren - npop) > 2), 32'd0);
      if (done) begin
        chk({nm, " busy at done"}, 32'(busy), 32'd1);
        if (exp_done_cyc != 0) begin
          chk({nm, " done cycle"},  32'(cyc),         32'(exp_done_cyc));
          chk({nm, " first valid"}, 32'(first_valid), 32'd3);
          chk({nm, " last ren"},    32'(last_ren),    32'(l));
        end
        fin = 1'b1;
      end
    end
    start = 1'b0;
    if (!fin) chk({nm, " timeout"}, 32'd0, 32'd1);
    chk({nm, " reads"},  32'(nren),  32'(l));
    chk({nm, " pixels"}, 32'(npop),  32'(l));
    chk({nm, " lasts"},  32'(nlast), 32'd1);
    @(negedge clk); #1;
    chk({nm, " done pulse"}, 32'(done), 32'd0);
    chk({nm, " idle busy"},  32'(busy), 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; base_addr = '0; len = '0; pix_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    run_xfer("basic", 8'h10, 9'd8, 16'hFFFF, 0, 11, 40);
    run_xfer("stall", 8'h10, 9'd8, 16'b1001_1001_0110_1001, 0, 0, 80);
    run_xfer("wrap", 8'hFE, 9'd4, 16'hFFFF, 0, 7, 30);

    do_start(8'h33, 9'd0);
    #1;
    chk("len0 c1 done",  32'(done),      32'd1);
    chk("len0 c1 busy",  32'(busy),      32'd1);
    chk("len0 c1 ren",   32'(ren),       32'd0);
    chk("len0 c1 valid", 32'(pix_valid), 32'd0);
    @(negedge clk); #1;
    chk("len0 c2 done",  32'(done),      32'd0);
    chk("len0 c2 busy",  32'(busy),      32'd0);
    chk("len0 c2 ren",   32'(ren),       32'd0);
    chk("len0 c2 valid", 32'(pix_valid), 32'd0);

    run_xfer("full", 8'h00, 9'd256, 16'hFFFF, 0, 259, 300);
    run_xfer("restart", 8'h40, 9'd6, 16'b1110_1101_1011_0111, 4, 0, 60);

    // Asynchronous reset in the middle of a stalled transfer
    pix_ready = 1'b0;
    do_start(8'h20, 9'd8);
    repeat (5) @(negedge clk);
    #1;
    chk("pre-reset busy",  32'(busy),      32'd1);
    chk("pre-reset valid", 32'(pix_valid), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk_all_zero("async rst");
    @(negedge clk);
    rst = 1'b0;
    run_xfer("post-rst", 8'h05, 9'd5, 16'hFFFF, 0, 8, 30);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
